// File: rtl/calculator.sv
// calculator: single-cycle 4-bit ALU with registered 8-bit result.
//
// Ports:
//   clk     - clock; all state updates on the rising edge
//   rst_n   - synchronous active-low reset; clears out and div_err
//   a, b    - 4-bit unsigned operands
//   oper    - operation select:
//               000 add, 001 sub, 010 mul, 011 div,
//               100 mod, 101 and, 110 or,  111 xor
//   out     - registered 8-bit result, one cycle after the inputs are sampled
//   div_err - registered flag, set when div/mod is attempted with b == 0
module calculator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] oper,
  output logic [7:0] out,
  output logic       div_err
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpMod = 3'b100;
  localparam logic [2:0] OpAnd = 3'b101;
  localparam logic [2:0] OpOr  = 3'b110;
  localparam logic [2:0] OpXor = 3'b111;

  logic [7:0] a_ext;
  logic [7:0] b_ext;
  logic [7:0] res_d;
  logic       err_d;
  logic [7:0] res_q;
  logic       err_q;

  // Operands widened up front so every operation is evaluated in 8 bits;
  // subtraction then wraps as 8-bit two's complement.
  assign a_ext = {4'b0000, a};
  assign b_ext = {4'b0000, b};

  always_comb begin
    res_d = 8'h00;
    err_d = 1'b0;
    unique case (oper)
      OpAdd: res_d = a_ext + b_ext;
      OpSub: res_d = a_ext - b_ext;
      OpMul: res_d = a_ext * b_ext;
      OpDiv: begin
        // Divisor of zero is steered away from the divider; result forced.
        if (b == 4'd0) begin
          res_d = 8'hFF;
          err_d = 1'b1;
        end else begin
          res_d = a_ext / b_ext;
        end
      end
      OpMod: begin
        if (b == 4'd0) begin
          res_d = 8'hFF;
          err_d = 1'b1;
        end else begin
          res_d = a_ext % b_ext;
        end
      end
      OpAnd: res_d = {4'b0000, a & b};
      OpOr:  res_d = {4'b0000, a | b};
      OpXor: res_d = {4'b0000, a ^ b};
      default: begin
        res_d = 8'h00;
        err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      res_q <= res_d;
      err_q <= err_d;
    end
  end

  assign out     = res_q;
  assign div_err = err_q;

endmodule

// File: tb/tb_calculator.sv
// tb_calculator: self-checking bench for calculator. A behavioural model
// predicts out/div_err from the inputs seen at each rising edge; a compare
// process checks the DUT every falling edge once reset has been applied.
// Directed literal checks pin the model to known answers.
module tb_calculator;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] oper;
  logic [7:0] out;
  logic       div_err;

  int total;
  int bad;

  logic [7:0] exp_out;
  logic       exp_err;
  logic       exp_valid;

  calculator dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .oper    (oper),
    .out     (out),
    .div_err (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic on plain integers.
  function automatic int model_out(input int x, input int y, input int op);
    case (op)
      0: return x + y;
      1: return (x - y) & 255;
      2: return x * y;
      3: return (y == 0) ? 255 : x / y;
      4: return (y == 0) ? 255 : x % y;
      5: return x & y;
      6: return x | y;
      default: return x ^ y;
    endcase
  endfunction

  function automatic bit model_err(input int y, input int op);
    return (op == 3 || op == 4) && (y == 0);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_out   <= 8'h00;
      exp_err   <= 1'b0;
      exp_valid <= 1'b1;
    end else if (exp_valid) begin
      exp_out <= 8'(model_out(int'(a), int'(b), int'(oper)));
      exp_err <= model_err(int'(b), int'(oper));
    end
  end

  task automatic check(input string name, input logic [7:0] got_o, input logic got_e,
                       input logic [7:0] req_o, input logic req_e);
    total++;
    if (got_o !== req_o || got_e !== req_e) begin
      bad++;
      $display("FAIL %s: got out=%h div_err=%b, required out=%h div_err=%b",
               name, got_o, got_e, req_o, req_e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid === 1'b1) check("model", out, div_err, exp_out, exp_err);
  end

  // Apply inputs, let one rising edge sample them, return 1 time unit later.
  task automatic cyc(input logic rs, input logic [3:0] ia, input logic [3:0] ib,
                     input logic [2:0] op);
    rst_n = rs;
    a     = ia;
    b     = ib;
    oper  = op;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    total     = 0;
    bad       = 0;
    exp_valid = 1'b0;
    exp_out   = 8'h00;
    exp_err   = 1'b0;
    sweep_exp = '{8'h15, 8'h09, 8'h5A, 8'h02, 8'h03, 8'h06, 8'h0F, 8'h09};
    rst_n = 1'b0;
    a     = 4'd15;
    b     = 4'd6;
    oper  = 3'b010;
    #2;

    cyc(1'b0, 4'd15, 4'd6, 3'b010);
    check("reset_edge1", out, div_err, 8'h00, 1'b0);
    cyc(1'b0, 4'd15, 4'd6, 3'b010);
    check("reset_edge2", out, div_err, 8'h00, 1'b0);

    for (int op = 0; op < 8; op++) begin
      cyc(1'b1, 4'b1111, 4'b0110, 3'(op));
      check($sformatf("sweep_op%0d", op), out, div_err, sweep_exp[op], 1'b0);
    end

    cyc(1'b1, 4'd3, 4'd5, 3'b001);
    check("sub_3_5", out, div_err, 8'hFE, 1'b0);
    cyc(1'b1, 4'd0, 4'd15, 3'b001);
    check("sub_0_15", out, div_err, 8'hF1, 1'b0);

    cyc(1'b1, 4'd9, 4'd0, 3'b011);
    check("div_by_zero", out, div_err, 8'hFF, 1'b1);
    cyc(1'b1, 4'd9, 4'd0, 3'b000);
    check("add_after_div0", out, div_err, 8'h09, 1'b0);
    cyc(1'b1, 4'd9, 4'd0, 3'b100);
    check("mod_by_zero", out, div_err, 8'hFF, 1'b1);

    cyc(1'b1, 4'd15, 4'd15, 3'b010);
    check("ext_mul", out, div_err, 8'hE1, 1'b0);
    cyc(1'b1, 4'd15, 4'd15, 3'b000);
    check("ext_add", out, div_err, 8'h1E, 1'b0);
    cyc(1'b1, 4'd15, 4'd15, 3'b011);
    check("ext_div", out, div_err, 8'h01, 1'b0);
    cyc(1'b1, 4'd15, 4'd15, 3'b100);
    check("ext_mod", out, div_err, 8'h00, 1'b0);

    cyc(1'b1, 4'd7, 4'd7, 3'b010);
    cyc(1'b0, 4'd7, 4'd7, 3'b010);
    check("mid_reset", out, div_err, 8'h00, 1'b0);
    cyc(1'b1, 4'd2, 4'd3, 3'b000);
    check("post_reset", out, div_err, 8'h05, 1'b0);

    // Random traffic with occasional reset; checked by the compare process.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 15) != 0), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
          3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
